// File: rtl/fetch_scheduler_if.sv
// Fetch scheduler bus: warp status, PC redirect, host load, cache port, fetch output.
// master = environment side, slave = scheduler side.
interface fetch_scheduler_if #(
  parameter int NUM_WARPS = 8,
  parameter int ADDR      = 12,
  parameter int DATA      = 32
);
  localparam int WID = $clog2(NUM_WARPS);

  logic [NUM_WARPS-1:0] warp_active;
  logic [NUM_WARPS-1:0] ibuf_ready;
  logic                 pc_set_valid;
  logic [WID-1:0]       pc_set_warp;
  logic [ADDR-1:0]      pc_set_pc;
  logic                 ld_valid;
  logic [ADDR-1:0]      ld_addr;
  logic [DATA-1:0]      ld_data;
  logic [ADDR-1:0]      ic_addr;
  logic                 ic_wr;
  logic [DATA-1:0]      ic_din;
  logic [DATA-1:0]      ic_dout;
  logic                 fetch_valid;
  logic [WID-1:0]       fetch_warp;
  logic [ADDR-1:0]      fetch_pc;
  logic [DATA-1:0]      fetch_instr;

  modport master (
    output warp_active, ibuf_ready,
    output pc_set_valid, pc_set_warp, pc_set_pc,
    output ld_valid, ld_addr, ld_data,
    output ic_dout,
    input  ic_addr, ic_wr, ic_din,
    input  fetch_valid, fetch_warp, fetch_pc, fetch_instr
  );

  modport slave (
    input  warp_active, ibuf_ready,
    input  pc_set_valid, pc_set_warp, pc_set_pc,
    input  ld_valid, ld_addr, ld_data,
    input  ic_dout,
    output ic_addr, ic_wr, ic_din,
    output fetch_valid, fetch_warp, fetch_pc, fetch_instr
  );
endinterface

// File: rtl/fetch_scheduler.sv
// Round-robin I-cache fetch scheduler: per-warp PCs, 2-cycle read tracking, host-load mux.
// Ports: clk, rst (async high), bus (fetch_scheduler_if.slave).
module fetch_scheduler #(
  parameter int NUM_WARPS = 8,
  parameter int ADDR      = 12,
  parameter int DATA      = 32
) (
  input logic               clk,
  input logic               rst,
  fetch_scheduler_if.slave  bus
);
  localparam int WID = $clog2(NUM_WARPS);

  typedef logic [WID-1:0]  wid_t;
  typedef logic [ADDR-1:0] addr_t;
  typedef struct packed {
    logic  valid;
    wid_t  warp;
    addr_t pc;
  } stage_t;

  logic [NUM_WARPS-1:0][ADDR-1:0] pc_q, pc_d;
  logic [NUM_WARPS-1:0]           inflight_q, inflight_d;
  wid_t                           last_q, last_d;
  stage_t                         s1_q, s1_d;
  stage_t                         s2_q, s2_d;
  addr_t                          hold_q, hold_d;

  logic [NUM_WARPS-1:0] elig;
  logic                 found;
  logic                 issue;
  wid_t                 win;
  wid_t                 idx;
  addr_t                ic_addr_c;

  // Search starts just after the last winner; the final step wraps to last itself.
  always_comb begin
    elig  = '0;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig[w] = bus.warp_active[w] & bus.ibuf_ready[w] & ~inflight_q[w]
              & ~(bus.pc_set_valid && bus.pc_set_warp == wid_t'(w));
    end
    for (int i = 1; i <= NUM_WARPS; i++) begin
      idx = last_q + wid_t'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    issue = found & ~bus.ld_valid;
  end

  always_comb begin
    ic_addr_c = hold_q;
    if (bus.ld_valid) begin
      ic_addr_c = bus.ld_addr;
    end else if (issue) begin
      ic_addr_c = pc_q[win];
    end
  end

  assign bus.ic_addr     = ic_addr_c;
  assign bus.ic_wr       = bus.ld_valid;
  assign bus.ic_din      = bus.ld_data;
  assign bus.fetch_valid = s2_q.valid;
  assign bus.fetch_warp  = s2_q.warp;
  assign bus.fetch_pc    = s2_q.pc;
  assign bus.fetch_instr = bus.ic_dout;

  // pc_set is applied last so it overrides issue and retire for its warp.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    last_d     = last_q;
    s1_d       = '0;
    s2_d       = s1_q;
    hold_d     = ic_addr_c;
    if (s2_q.valid) begin
      inflight_d[s2_q.warp] = 1'b0;
    end
    if (issue) begin
      last_d         = win;
      pc_d[win]      = pc_q[win] + 1'b1;
      inflight_d[win] = 1'b1;
      s1_d.valid     = 1'b1;
      s1_d.warp      = win;
      s1_d.pc        = pc_q[win];
    end
    if (bus.pc_set_valid) begin
      pc_d[bus.pc_set_warp]       = bus.pc_set_pc;
      inflight_d[bus.pc_set_warp] = 1'b0;
      if (s1_q.warp == bus.pc_set_warp) begin
        s2_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      inflight_q <= '0;
      last_q     <= wid_t'(NUM_WARPS - 1);
      s1_q       <= '0;
      s2_q       <= '0;
      hold_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      last_q     <= last_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      hold_q     <= hold_d;
    end
  end
endmodule

// File: tb/tb_fetch_scheduler.sv
// Testbench for fetch_scheduler: cycle-level scoreboard plus directed scenarios.
// Drives the bus through fetch_scheduler_if and models the 2-cycle I-cache.
module tb_fetch_scheduler;
  localparam int NW = 8;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_scheduler_if #(.NUM_WARPS(NW), .ADDR(AW), .DATA(DW)) ifc ();

  fetch_scheduler #(.NUM_WARPS(NW), .ADDR(AW), .DATA(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  function automatic logic [31:0] init_val(int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Cache: write on the edge, read data two edges after address.
  logic [31:0] mem [0:4095];
  logic [31:0] rd1;
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
    rd1 = '0;
    ifc.ic_dout = '0;
  end
  always @(posedge clk) begin
    if (ifc.ic_wr) mem[ifc.ic_addr] <= ifc.ic_din;
    rd1 <= mem[ifc.ic_addr];
    ifc.ic_dout <= rd1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model: fetches keyed by the cycle they must appear.
  typedef struct {
    int          w;
    int          pc;
    logic [31:0] instr;
  } rec_t;
  typedef struct {
    int          cyc;
    int          w;
    int          pc;
    logic [31:0] instr;
  } ent_t;

  rec_t        outs [int];
  ent_t        log_q [$];
  int          mpc [NW];
  int          free_at [NW];
  int          mlast;
  int          m_icaddr;
  int          cyc;
  logic [31:0] mmem [0:4095];

  initial begin
    for (int i = 0; i < 4096; i++) mmem[i] = init_val(i);
  end

  task automatic model_reset();
    outs.delete();
    for (int w = 0; w < NW; w++) begin
      mpc[w] = 0;
      free_at[w] = 0;
    end
    mlast = NW - 1;
    m_icaddr = 0;
    cyc = 0;
  endtask

  always @(negedge clk) begin
    int   win;
    int   w;
    int   exp_addr;
    logic exp_v;
    rec_t r;
    if (rst) begin
      model_reset();
      chk("rst_fetch_valid", 64'(ifc.fetch_valid), 0);
      chk("rst_fetch_warp", 64'(ifc.fetch_warp), 0);
      chk("rst_fetch_pc", 64'(ifc.fetch_pc), 0);
      chk("rst_ic_wr", 64'(ifc.ic_wr), 0);
      chk("rst_ic_addr", 64'(ifc.ic_addr), 0);
    end else begin
      win = -1;
      if (!ifc.ld_valid) begin
        for (int k = 1; k <= NW; k++) begin
          w = (mlast + k) % NW;
          if (win < 0 && ifc.warp_active[w] && ifc.ibuf_ready[w]
              && cyc >= free_at[w]
              && !(ifc.pc_set_valid && int'(ifc.pc_set_warp) == w))
            win = w;
        end
      end
      exp_addr = ifc.ld_valid ? int'(ifc.ld_addr)
               : (win >= 0) ? mpc[win] : m_icaddr;
      chk("ic_wr", 64'(ifc.ic_wr), 64'(ifc.ld_valid));
      chk("ic_addr", 64'(ifc.ic_addr), 64'(exp_addr));
      chk("ic_din", 64'(ifc.ic_din), 64'(ifc.ld_data));
      exp_v = outs.exists(cyc);
      chk("fetch_valid", 64'(ifc.fetch_valid), 64'(exp_v));
      if (exp_v) begin
        r = outs[cyc];
        chk("fetch_warp", 64'(ifc.fetch_warp), 64'(r.w));
        chk("fetch_pc", 64'(ifc.fetch_pc), 64'(r.pc));
        chk("fetch_instr", 64'(ifc.fetch_instr), 64'(r.instr));
      end
      if (ifc.fetch_valid)
        log_q.push_back('{cyc, int'(ifc.fetch_warp), int'(ifc.fetch_pc),
                          ifc.fetch_instr});
      m_icaddr = exp_addr;
      if (ifc.ld_valid) mmem[ifc.ld_addr] = ifc.ld_data;
      if (win >= 0) begin
        outs[cyc + 2] = '{win, mpc[win], mmem[mpc[win]]};
        free_at[win] = cyc + 3;
        mpc[win] = (mpc[win] + 1) % 4096;
        mlast = win;
      end
      if (ifc.pc_set_valid) begin
        w = int'(ifc.pc_set_warp);
        mpc[w] = int'(ifc.pc_set_pc);
        free_at[w] = 0;
        if (outs.exists(cyc + 1) && outs[cyc + 1].w == w)
          outs.delete(cyc + 1);
      end
      outs.delete(cyc);
      cyc++;
    end
  end

  function automatic ent_t lg(int k);
    ent_t e;
    e = '{-1, -1, -1, '0};
    if (k < log_q.size()) e = log_q[k];
    return e;
  endfunction

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    ifc.warp_active  = '0;
    ifc.ibuf_ready   = '1;
    ifc.pc_set_valid = 1'b0;
    ifc.pc_set_warp  = '0;
    ifc.pc_set_pc    = '0;
    ifc.ld_valid     = 1'b0;
    ifc.ld_addr      = '0;
    ifc.ld_data      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step(2);
    rst = 1'b0;
    log_q.delete();
  endtask

  initial begin
    int cnt;
    int r0;
    int fc;
    idle_inputs();
    step(1);

    // Round robin over warps 0-3.
    do_reset();
    ifc.warp_active = 8'h0F;
    step(12);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_warp%0d", k), 64'(lg(k).w), 64'(k % 4));
      chk($sformatf("rr_pc%0d", k), 64'(lg(k).pc), 64'(k / 4));
    end
    chk("rr_first_cyc", 64'(lg(0).cyc), 2);
    chk("rr_pc0_at8", 64'(lg(8).pc), 2);

    // Single warp, PC wrap.
    do_reset();
    ifc.pc_set_valid = 1'b1;
    ifc.pc_set_warp  = 3'd5;
    ifc.pc_set_pc    = 12'hFFF;
    step(1);
    ifc.pc_set_valid = 1'b0;
    ifc.warp_active  = 8'h20;
    step(10);
    chk("wrap_pc0", 64'(lg(0).pc), 64'h0FFF);
    chk("wrap_pc1", 64'(lg(1).pc), 64'h0000);
    chk("wrap_pc2", 64'(lg(2).pc), 64'h0001);
    chk("wrap_gap", 64'(lg(1).cyc - lg(0).cyc), 3);
    chk("wrap_warp", 64'(lg(0).w), 5);

    // Host load then fetch it.
    do_reset();
    ifc.ld_valid = 1'b1;
    ifc.ld_addr  = 12'h010;
    ifc.ld_data  = 32'hA5A5A5A5;
    step(1);
    ifc.ld_valid     = 1'b0;
    ifc.pc_set_valid = 1'b1;
    ifc.pc_set_warp  = 3'd0;
    ifc.pc_set_pc    = 12'h010;
    step(1);
    ifc.pc_set_valid = 1'b0;
    ifc.warp_active  = 8'h01;
    step(8);
    chk("load_pc", 64'(lg(0).pc), 64'h010);
    chk("load_instr", 64'(lg(0).instr), 64'hA5A5A5A5);
    chk("load_next", 64'(lg(1).instr), 64'hC0DE0011);
    ifc.warp_active = 8'h0F;
    step(3);
    ifc.ld_valid = 1'b1;
    ifc.ld_addr  = 12'h200;
    ifc.ld_data  = 32'h11112222;
    step(1);
    ifc.ld_valid = 1'b0;
    step(2);
    ifc.ld_valid = 1'b1;
    ifc.ld_addr  = 12'h201;
    ifc.ld_data  = 32'h33334444;
    step(1);
    ifc.ld_valid = 1'b0;
    step(8);

    // Kill of an in-flight fetch by redirect.
    do_reset();
    ifc.pc_set_valid = 1'b1;
    ifc.pc_set_warp  = 3'd2;
    ifc.pc_set_pc    = 12'h020;
    step(1);
    ifc.pc_set_valid = 1'b0;
    ifc.warp_active  = 8'h04;
    step(1);
    ifc.pc_set_valid = 1'b1;
    ifc.pc_set_pc    = 12'h100;
    step(1);
    ifc.pc_set_valid = 1'b0;
    step(8);
    chk("kill_first_pc", 64'(lg(0).pc), 64'h100);
    chk("kill_first_cyc", 64'(lg(0).cyc), 5);
    cnt = 0;
    foreach (log_q[i]) if (log_q[i].pc == 'h20) cnt++;
    chk("kill_no_020", 64'(cnt), 0);

    // ibuf_ready gating.
    do_reset();
    ifc.warp_active = 8'h07;
    ifc.ibuf_ready  = 8'hFD;
    step(9);
    cnt = 0;
    foreach (log_q[i]) if (log_q[i].w == 1) cnt++;
    chk("ibuf_no_w1", 64'(cnt), 0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("ibuf_alt%0d", k), 64'(lg(k).w), 64'((k % 2) * 2));
    r0 = cyc;
    ifc.ibuf_ready = 8'hFF;
    step(6);
    fc = -1;
    foreach (log_q[i]) if (fc < 0 && log_q[i].w == 1) fc = log_q[i].cyc;
    chk("ibuf_w1_soon", 64'(fc >= 0 && fc <= r0 + 3), 1);

    // Async reset mid-fetch.
    do_reset();
    ifc.warp_active = 8'hFF;
    step(3);
    chk("midrst_before", 64'(ifc.fetch_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_drop", 64'(ifc.fetch_valid), 0);
    step(2);
    rst = 1'b0;
    log_q.delete();
    step(5);
    chk("midrst_w0", 64'(lg(0).w), 0);
    chk("midrst_cyc", 64'(lg(0).cyc), 2);

    idle_inputs();
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_scheduler.md
# fetch_scheduler

Round-robin instruction-fetch scheduler that shares the instruction cache's read port among `NUM_WARPS` warps. It sits between the per-warp PC state and the instruction buffer. Each cycle it picks one eligible warp, drives that warp's PC as the cache address and tracks the 2-cycle pipelined cache read latency. It then presents the returned instruction tagged with warp ID and PC. It also owns per-warp PC registers (init/branch redirect with in-flight kill) and muxes host program-load writes onto the same cache port, with host priority.

## Interface
- `NUM_WARPS`, 8, number of warps (power of 2, ≥2); `WID = log2(NUM_WARPS)`
- `ADDR`, 12, instruction word-address width
- `DATA`, 32, instruction width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `warp_active`  in  NUM_WARPS  warp is running (level)
- `ibuf_ready`  in  NUM_WARPS  ibuffer slot reserved for this warp's next fetch
- `pc_set_valid`  in  1  load a warp PC (init or branch redirect)
- `pc_set_warp`  in  WID  target warp
- `pc_set_pc`  in  ADDR  new PC
- `ld_valid`  in  1  host program-load write this cycle (always accepted)
- `ld_addr`  in  ADDR  load address
- `ld_data`  in  DATA  load data
- `ic_addr`  out  ADDR  cache port address
- `ic_wr`  out  1  cache port write enable
- `ic_din`  out  DATA  cache port write data
- `ic_dout`  in  DATA  cache port read data (valid 2 edges after address)
- `fetch_valid`  out  1  returned instruction valid
- `fetch_warp`  out  WID  warp of returned instruction
- `fetch_pc`  out  ADDR  PC of returned instruction
- `fetch_instr`  out  DATA  instruction (= `ic_dout`)

## Operation
- State: `pc[w]` (ADDR bits), `inflight[w]`, round-robin pointer `last` (WID), stage registers `s1`/`s2` = {valid, warp, pc}.
- Eligible(w) = `warp_active[w] & ibuf_ready[w] & ~inflight[w]` and not (`pc_set_valid & pc_set_warp==w`).
- Port mux (combinational):
  - If `ld_valid`: `ic_wr=1`, `ic_addr=ld_addr`, `ic_din=ld_data`, no issue.
  - Else if any warp is eligible: issue the winner, with `ic_addr=pc[winner]`, `ic_wr=0`.
  - Otherwise `ic_addr` holds the last value, `ic_wr=0`.
  - `ic_din` is `ld_data` whenever `ic_wr` is 0.
- Arbitration: the winner is the first eligible warp searching `last+1, last+2, …` modulo NUM_WARPS.
- On issue (at the clock edge):
  - `last ← winner`
  - `pc[winner] ← pc[winner]+1`, wrapping 2^ADDR-1 → 0
  - `inflight[winner] ← 1`
  - `s1 ← {1, winner, issued pc}`
- Otherwise `s1.valid ← 0`. `s2 ← s1` every cycle.
- Outputs: `fetch_valid = s2.valid`, `fetch_warp = s2.warp`, `fetch_pc = s2.pc`, `fetch_instr = ic_dout`.
- Retire: when `s2.valid`, `inflight[s2.warp]` clears at the edge ending that cycle.
- `pc_set` behaviour:
  - At the edge: `pc[pc_set_warp] ← pc_set_pc` and `inflight[pc_set_warp] ← 0`.
  - Any `s1`/`s2` entry with matching warp has its valid cleared at the same edge (killed, never output).
  - In the `pc_set` cycle itself, a matching `s2` entry is still output.
  - `pc_set` overrides increment and inflight set/clear for that warp.
- `ibuf_ready` is sampled only at issue. The ibuffer must hold a slot for the in-flight fetch.

## Timing
- Reset (async, immediate): all `pc=0`, `inflight=0`, `last=NUM_WARPS-1` (warp 0 wins first), `s1`/`s2` invalid, `fetch_valid=0`, `fetch_warp=0`, `fetch_pc=0`, `ic_wr=0`, `ic_addr=0`. Reset mid-fetch drops all in-flight results.
- Issue in cycle T → `fetch_valid` in cycle T+2 with `ic_dout` aligned.
- A warp can re-issue no earlier than T+3, so one warp alone gets 1 fetch per 3 cycles. Three or more eligible warps sustain 1 fetch/cycle.
- A load cycle stalls issue for exactly that cycle. In-flight reads still complete on schedule.
- Read-after-load to the same address returns the new data if the load edge precedes the read issue edge.

## Test plan
- Reset, warps 0–3 active, all ready, all PCs 0 → issues in cycles 0..7 go warp 0,1,2,3,0,1,2,3. The first `fetch_valid` is in cycle 2 with warp 0, pc 0. At cycle 8, `pc[0..3]=2`.
- Only warp 5 active, `pc[5]` set to 0xFFF → fetch pcs 0xFFF, 0x000, 0x001, issued every 3rd cycle.
- Host loads 0xA5A5A5A5 to addr 0x010 at cycle 0, then `pc_set` warp 0 to 0x010 → `fetch_instr=0xA5A5A5A5`, `fetch_pc=0x010`. Two `ld_valid` cycles amid fetching produce two issue bubbles and no lost `fetch_valid`.
- Warp 2 issues pc 0x020 at T; `pc_set` warp 2 to 0x100 at T+1 → no output for 0x020, `inflight[2]` cleared, next warp 2 fetch is pc 0x100.
- `ibuf_ready[1]=0` with warps 0–2 active → warp 1 is never issued and the others alternate. Raising `ibuf_ready[1]` gets warp 1 issued within 2 cycles.
- `rst` asserted while `s1`/`s2` are valid → `fetch_valid` drops at once. After release, warp 0 is issued first.
